// File: rtl/data_memory_responder_if.sv
// Request/response bus between the core's data port and the memory responder.
// master = core side, slave = responder side.
interface data_memory_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_address;
    logic [31:0] req_write_data;
    logic [2:0]  req_format;
    logic        resp_valid;
    logic [31:0] resp_read_data;
    logic        resp_error;

    modport master (
        output req_valid, req_write, req_address,
        output req_write_data, req_format,
        input  req_ready, resp_valid, resp_read_data, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_address,
        input  req_write_data, req_format,
        output req_ready, resp_valid, resp_read_data, resp_error
    );
endinterface

// File: rtl/data_memory_responder.sv
// Data-memory responder: one RV32 load/store per handshake against a word RAM,
// with configurable latency, byte-lane steering, load extension and error flag.
module data_memory_responder #(
    parameter int          ADDR_WIDTH   = 10,
    parameter int          LATENCY      = 1,
    parameter logic [31:0] BASE_ADDRESS = 32'h0001_0000
) (
    input  logic clock,
    input  logic reset,
    data_memory_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [29:0] BASE_WORD = BASE_ADDRESS[31:2];

    state_t      state;
    logic [3:0]  counter;
    logic        lat_write;
    logic [31:0] lat_address;
    logic [31:0] lat_write_data;
    logic [2:0]  lat_format;
    logic        resp_valid;
    logic [31:0] resp_read_data;
    logic        resp_error;

    logic [31:0] mem [2**ADDR_WIDTH];

    logic        accept;
    logic        commit;
    logic        sel_write;
    logic [31:0] sel_address;
    logic [31:0] sel_write_data;
    logic [2:0]  sel_format;

    assign accept = bus.req_valid && (state == IDLE);
    assign commit = (state == WAIT && counter == 4'd0)
                 || (accept && LATENCY == 0);

    // With zero latency the commit happens on the accept edge,
    // so the live request must be used instead of the latch.
    assign sel_write      = (state == IDLE) ? bus.req_write      : lat_write;
    assign sel_address    = (state == IDLE) ? bus.req_address    : lat_address;
    assign sel_write_data = (state == IDLE) ? bus.req_write_data : lat_write_data;
    assign sel_format     = (state == IDLE) ? bus.req_format     : lat_format;

    logic [29:0]           word_off;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  below_base;
    logic                  out_of_range;

    // Word-granular subtraction; BASE_ADDRESS is word aligned.
    assign word_off     = sel_address[31:2] - BASE_WORD;
    assign idx          = word_off[ADDR_WIDTH-1:0];
    assign below_base   = sel_address < BASE_ADDRESS;
    assign out_of_range = |word_off[29:ADDR_WIDTH];

    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_word = mem[idx];
    assign rd_byte = rd_word[{sel_address[1:0], 3'b000} +: 8];
    assign rd_half = sel_address[1] ? rd_word[31:16] : rd_word[15:0];

    logic        bad_format;
    logic        misaligned;
    logic        error;
    logic [3:0]  byte_en;
    logic [31:0] wr_word;
    logic [31:0] load_data;

    always_comb begin
        bad_format = 1'b0;
        misaligned = 1'b0;
        byte_en    = 4'b0000;
        wr_word    = sel_write_data;
        load_data  = 32'd0;
        unique case (sel_format)
            3'b000: begin
                byte_en   = 4'b0001 << sel_address[1:0];
                wr_word   = {4{sel_write_data[7:0]}};
                load_data = {{24{rd_byte[7]}}, rd_byte};
            end
            3'b001: begin
                misaligned = sel_address[0];
                byte_en    = sel_address[1] ? 4'b1100 : 4'b0011;
                wr_word    = {2{sel_write_data[15:0]}};
                load_data  = {{16{rd_half[15]}}, rd_half};
            end
            3'b010: begin
                misaligned = |sel_address[1:0];
                byte_en    = 4'b1111;
                load_data  = rd_word;
            end
            3'b100: begin
                bad_format = sel_write;
                load_data  = {24'd0, rd_byte};
            end
            3'b101: begin
                bad_format = sel_write;
                misaligned = sel_address[0];
                load_data  = {16'd0, rd_half};
            end
            default: bad_format = 1'b1;
        endcase
    end

    assign error = bad_format || misaligned
                || below_base || out_of_range;

    // RAM is not reset; an in-flight request cut by reset never writes.
    always_ff @(posedge clock) begin
        if (commit && !reset && !error && sel_write) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[idx][8*b +: 8] <= wr_word[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            counter        <= 4'd0;
            lat_write      <= 1'b0;
            lat_address    <= 32'd0;
            lat_write_data <= 32'd0;
            lat_format     <= 3'd0;
            resp_valid     <= 1'b0;
            resp_read_data <= 32'd0;
            resp_error     <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        lat_write      <= bus.req_write;
                        lat_address    <= bus.req_address;
                        lat_write_data <= bus.req_write_data;
                        lat_format     <= bus.req_format;
                        if (LATENCY == 0) begin
                            state <= RESP;
                        end else begin
                            state   <= WAIT;
                            counter <= 4'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (counter == 4'd0) begin
                        state <= RESP;
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
            if (commit) begin
                resp_valid     <= 1'b1;
                resp_error     <= error;
                resp_read_data <= (error || sel_write) ? 32'd0 : load_data;
            end
        end
    end

    assign bus.req_ready      = (state == IDLE);
    assign bus.resp_valid     = resp_valid;
    assign bus.resp_read_data = resp_read_data;
    assign bus.resp_error     = resp_error;
endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: a LATENCY=1 and a LATENCY=3
// instance, directed loads/stores, error cases and reset during WAIT.
module tb_data_memory_responder;
    logic clock = 1'b0;
    logic rst0;
    logic rst1;
    int   checks   = 0;
    int   failures = 0;

    logic [32:0] q0[$];
    logic [32:0] q1[$];

    data_memory_responder_if m0();
    data_memory_responder_if m1();

    data_memory_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut0 (
        .clock(clock), .reset(rst0), .bus(m0.slave)
    );
    data_memory_responder #(.ADDR_WIDTH(10), .LATENCY(3)) dut1 (
        .clock(clock), .reset(rst1), .bus(m1.slave)
    );

    always #5 clock = ~clock;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    task automatic chk(input string name, input logic [32:0] act,
                       input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitors: pop and compare whenever a response strobe is seen.
    always @(negedge clock) begin
        if (m0.resp_valid === 1'b1) begin
            if (q0.size() == 0) begin
                chk("dut0_unexpected_resp", 33'd1, 33'd0);
            end else begin
                chk("dut0_resp", {m0.resp_error, m0.resp_read_data},
                    q0.pop_front());
            end
        end
        if (m1.resp_valid === 1'b1) begin
            if (q1.size() == 0) begin
                chk("dut1_unexpected_resp", 33'd1, 33'd0);
            end else begin
                chk("dut1_resp", {m1.resp_error, m1.resp_read_data},
                    q1.pop_front());
            end
        end
    end

    task automatic drive(input int sel, input logic v, input logic wr,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f);
        if (sel == 0) begin
            m0.req_valid = v; m0.req_write = wr;
            m0.req_address = a; m0.req_write_data = d;
            m0.req_format = f;
        end else begin
            m1.req_valid = v; m1.req_write = wr;
            m1.req_address = a; m1.req_write_data = d;
            m1.req_format = f;
        end
    endtask

    task automatic issue(input int sel, input logic wr,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f, input logic [31:0] ed,
                         input logic ee, input bit expect_resp = 1'b1);
        int  lat;
        int  n;
        bit  seen;
        bit  ready_ok;
        logic rdy;
        logic vld;
        lat = (sel == 0) ? 1 : 3;
        if (expect_resp) begin
            if (sel == 0) q0.push_back({ee, ed});
            else          q1.push_back({ee, ed});
        end
        @(negedge clock);
        drive(sel, 1'b1, wr, a, d, f);
        @(posedge clock);
        #1;
        drive(sel, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        if (!expect_resp) return;
        n = 0;
        seen = 0;
        ready_ok = 1;
        while (!seen && n < 20) begin
            @(negedge clock);
            n++;
            rdy = (sel == 0) ? m0.req_ready  : m1.req_ready;
            vld = (sel == 0) ? m0.resp_valid : m1.resp_valid;
            if (rdy !== 1'b0) ready_ok = 0;
            if (vld === 1'b1) seen = 1;
        end
        if (!seen) begin
            chk("resp_timeout", 33'd0, 33'd1);
        end else begin
            chk("resp_latency", 33'(n), 33'(lat + 1));
            chk("ready_low_busy", 33'(ready_ok), 33'd1);
        end
    endtask

    initial begin
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        rst0 = 1'b1;
        rst1 = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_ready", 33'(m0.req_ready), 33'd1);
        chk("rst_valid", 33'(m0.resp_valid), 33'd0);
        chk("rst_resp", {m0.resp_error, m0.resp_read_data}, 33'd0);
        rst0 = 1'b0;
        rst1 = 1'b0;

        issue(0, 1, 32'h10008, 32'hDEADBEEF, F_W, 32'h0, 0);
        issue(0, 0, 32'h10008, 32'h0, F_W, 32'hDEADBEEF, 0);
        issue(0, 1, 32'h10009, 32'h00000080, F_B, 32'h0, 0);
        issue(0, 0, 32'h10009, 32'h0, F_B, 32'hFFFFFF80, 0);
        issue(0, 0, 32'h10009, 32'h0, F_BU, 32'h00000080, 0);
        issue(0, 0, 32'h10008, 32'h0, F_W, 32'hDEAD80EF, 0);
        issue(0, 1, 32'h1000B, 32'h123456AA, F_B, 32'h0, 0);
        issue(0, 0, 32'h10008, 32'h0, F_W, 32'hAAAD80EF, 0);
        issue(0, 0, 32'h1000A, 32'h0, F_H, 32'hFFFFAAAD, 0);
        issue(0, 1, 32'h10000, 32'h80011234, F_W, 32'h0, 0);
        issue(0, 0, 32'h10002, 32'h0, F_H, 32'hFFFF8001, 0);
        issue(0, 0, 32'h10002, 32'h0, F_HU, 32'h00008001, 0);
        issue(0, 0, 32'h10000, 32'h0, F_H, 32'h00001234, 0);
        issue(0, 1, 32'h10002, 32'hCAFE5678, F_H, 32'h0, 0);
        issue(0, 0, 32'h10000, 32'h0, F_W, 32'h56781234, 0);
        issue(0, 1, 32'h10000, 32'h80011234, F_W, 32'h0, 0);

        issue(0, 0, 32'h10002, 32'h0, F_W, 32'h0, 1);
        issue(0, 1, 32'h10001, 32'hFFFFFFFF, F_H, 32'h0, 1);
        issue(0, 0, 32'h10000, 32'h0, F_W, 32'h80011234, 0);
        issue(0, 0, 32'h0FFFC, 32'h0, F_W, 32'h0, 1);
        issue(0, 0, 32'h11000, 32'h0, F_W, 32'h0, 1);
        issue(0, 0, 32'hFFFFFFFC, 32'h0, F_W, 32'h0, 1);
        issue(0, 0, 32'h10000, 32'h0, 3'b011, 32'h0, 1);
        issue(0, 1, 32'h10000, 32'hFFFFFFFF, F_BU, 32'h0, 1);
        issue(0, 1, 32'h11000, 32'hFFFFFFFF, F_W, 32'h0, 1);
        issue(0, 0, 32'h10000, 32'h0, F_W, 32'h80011234, 0);
        issue(0, 1, 32'h10FFC, 32'h12345678, F_W, 32'h0, 0);
        issue(0, 0, 32'h10FFC, 32'h0, F_W, 32'h12345678, 0);
        issue(0, 0, 32'h10000, 32'h0, F_W, 32'h80011234, 0);

        issue(1, 1, 32'h10010, 32'h00000001, F_W, 32'h0, 0);
        issue(1, 1, 32'h10010, 32'h00000005, F_W, 32'h0, 0, 1'b0);
        @(negedge clock);
        rst1 = 1'b1;
        repeat (2) begin
            @(negedge clock);
            chk("mid_wait_rst_valid", 33'(m1.resp_valid), 33'd0);
        end
        rst1 = 1'b0;
        repeat (4) begin
            @(negedge clock);
            chk("post_rst_valid", 33'(m1.resp_valid), 33'd0);
        end
        chk("post_rst_ready", 33'(m1.req_ready), 33'd1);
        issue(1, 0, 32'h10010, 32'h0, F_W, 32'h00000001, 0);

        repeat (3) @(negedge clock);
        chk("q0_drained", 33'(q0.size()), 33'd0);
        chk("q1_drained", 33'(q1.size()), 33'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
